// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM boundary register with valid/ready handshake and 2-entry skid buffer
module ex_mem_skid #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int CNT_W         = 16,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd,
    input  logic              regwe,
    input  logic [DATA_W-1:0] result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_o,
    output logic              regwe_o,
    output logic [DATA_W-1:0] wbdata,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_m_v;
    logic [ADDR_W-1:0] r_m_rd;
    logic              r_m_regwe;
    logic [DATA_W-1:0] r_m_data;
    logic              r_s_v;
    logic [ADDR_W-1:0] r_s_rd;
    logic              r_s_regwe;
    logic [DATA_W-1:0] r_s_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_accept;
    logic w_drain;
    logic w_m_free;
    logic w_zero_kill;

    // Readiness depends only on skid occupancy, breaking any out_ready -> in_ready path.
    assign in_ready    = !r_s_v;
    assign w_accept    = in_valid & in_ready;
    assign w_drain     = r_m_v & out_ready;
    assign w_m_free    = !r_m_v | w_drain;
    assign w_zero_kill = (ZERO_SUPPRESS != 0) && (r_m_rd == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_v     <= 1'b0;
            r_m_rd    <= '0;
            r_m_regwe <= 1'b0;
            r_m_data  <= '0;
            r_s_v     <= 1'b0;
            r_s_rd    <= '0;
            r_s_regwe <= 1'b0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_v <= 1'b0;
            r_s_v <= 1'b0;
        end else if (w_m_free) begin
            if (r_s_v) begin
                r_m_v     <= 1'b1;
                r_m_rd    <= r_s_rd;
                r_m_regwe <= r_s_regwe;
                r_m_data  <= r_s_data;
                r_s_v     <= w_accept;
                if (w_accept) begin
                    r_s_rd    <= rd;
                    r_s_regwe <= regwe;
                    r_s_data  <= result;
                end
            end else if (w_accept) begin
                r_m_v     <= 1'b1;
                r_m_rd    <= rd;
                r_m_regwe <= regwe;
                r_m_data  <= result;
            end else begin
                r_m_v <= 1'b0;
            end
        end else if (w_accept) begin
            r_s_v     <= 1'b1;
            r_s_rd    <= rd;
            r_s_regwe <= regwe;
            r_s_data  <= result;
        end
    end

    // Counts edges where a valid entry is held back; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
        end else if (r_m_v && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = r_m_v;
    assign rd_o      = r_m_rd;
    assign wbdata    = r_m_data;
    assign regwe_o   = r_m_v & r_m_regwe & !w_zero_kill;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - randomized and directed bench for ex_mem_skid against a queue model
module tb_ex_mem_skid;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic [AW-1:0] rd;
        logic          regwe;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, regwe, out_valid, out_ready, regwe_o, clr_cnt;
    logic [AW-1:0] rd, rd_o;
    logic [DW-1:0] result, wbdata;
    logic [CW-1:0] stall_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t q[$];
    logic [DW-1:0] obs[$];
    int   cnt_m = 0;

    always #5 clk = ~clk;

    ex_mem_skid #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .ZERO_SUPPRESS(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd(rd), .regwe(regwe), .result(result), .out_valid(out_valid), .out_ready(out_ready),
        .rd_o(rd_o), .regwe_o(regwe_o), .wbdata(wbdata), .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
    );

    // Model: the stage is a FIFO of at most two entries; ready whenever fewer than two are held.
    task automatic tick();
        bit   acc, drn;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if (out_valid && out_ready) obs.push_back(wbdata);
        if (clr_cnt) cnt_m = 0;
        else if (q.size() > 0 && !out_ready && !flush && cnt_m < CNT_MAX) cnt_m++;
        e = '{rd, regwe, result};
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] r, input logic we,
                         input logic [DW-1:0] d, input logic ordy);
        in_valid = v; rd = r; regwe = we; result = d; out_ready = ordy;
    endtask

    task automatic settle();
        drive(0, 0, 0, 0, 1);
        flush = 0;
        for (int i = 0; i < 4 && q.size() > 0; i++) tick();
        clr_cnt = 1; tick(); clr_cnt = 0;
        obs.delete();
    endtask

    task automatic test_reset();
        rst = 0; flush = 0; clr_cnt = 0;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0 || rd_o !== '0 || regwe_o !== 1'b0 || wbdata !== '0 ||
                stall_cnt !== '0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_vals: ov=%b rd=%0d we=%b wb=%h cnt=%0d ir=%b want 0/0/0/0/0/1",
                         out_valid, rd_o, regwe_o, wbdata, stall_cnt, in_ready);
            end
        end
        rst = 1; q.delete(); cnt_m = 0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        drive(1, 5, 1, 32'hDEADBEEF, 1);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || rd_o !== 5'd5 || regwe_o !== 1'b1 || wbdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL first_entry: ov=%b rd=%0d we=%b wb=%h want 1/5/1/deadbeef",
                     out_valid, rd_o, regwe_o, wbdata);
        end
    endtask

    task automatic test_stream();
        settle();
        for (int i = 1; i <= 8; i++) begin
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
            end
            drive(1, 5'(i), 1, DW'(i), 1);
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || wbdata !== DW'(i) || stall_cnt !== '0) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: ov=%b wb=%0d cnt=%0d want 1/%0d/0",
                         i, out_valid, wbdata, stall_cnt, i);
            end
        end
        drive(0, 0, 0, 0, 1);
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || obs.size() != 8) begin
            n_fail++;
            $display("FAIL stream_end: ov=%b delivered=%0d want 0/8", out_valid, obs.size());
        end
    endtask

    task automatic test_backpressure();
        int  waited;
        bit  taken;
        settle();
        drive(1, 1, 1, 32'h11, 0); tick();
        drive(1, 2, 1, 32'h22, 0); tick();
        drive(1, 3, 1, 32'h33, 0);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || wbdata !== 32'h11) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: ir=%b ov=%b wb=%h want 0/1/11", i, in_ready, out_valid, wbdata);
            end
            tick();
        end
        n_tests++;
        if (stall_cnt !== 4'd3 || stall_cnt !== CW'(cnt_m)) begin
            n_fail++; $display("FAIL bp_stall_cnt: got %0d want 3 (model %0d)", stall_cnt, cnt_m);
        end
        out_ready = 1;
        taken = 0; waited = 0;
        while (!taken && waited < 10) begin
            taken = in_ready;
            tick(); waited++;
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (!taken || obs.size() != 3) begin
            n_fail++; $display("FAIL bp_count: taken=%0d delivered=%0d want 1/3", taken, obs.size());
        end else if (obs[0] !== 32'h11 || obs[1] !== 32'h22 || obs[2] !== 32'h33) begin
            n_fail++;
            $display("FAIL bp_order: got %h %h %h want 11 22 33", obs[0], obs[1], obs[2]);
        end
    endtask

    task automatic test_flush();
        settle();
        drive(1, 1, 1, 32'hA1, 0); tick();
        drive(1, 2, 1, 32'hA2, 0); tick();
        drive(1, 4, 1, 32'h44, 0); flush = 1; tick(); flush = 0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_clear: ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_empty[%0d]: ov=%b want 0", i, out_valid);
            end
        end
        n_tests++;
        if (obs.size() != 0) begin
            n_fail++; $display("FAIL flush_leak: delivered=%0d want 0", obs.size());
        end
    endtask

    task automatic test_x0();
        settle();
        drive(1, 0, 1, 7, 1); tick();
        n_tests++;
        if (out_valid !== 1'b1 || regwe_o !== 1'b0 || wbdata !== 32'd7 || rd_o !== 5'd0) begin
            n_fail++;
            $display("FAIL x0_suppress: ov=%b we=%b wb=%0d rd=%0d want 1/0/7/0", out_valid, regwe_o, wbdata, rd_o);
        end
        drive(1, 3, 1, 9, 1); tick();
        n_tests++;
        if (out_valid !== 1'b1 || regwe_o !== 1'b1 || wbdata !== 32'd9) begin
            n_fail++; $display("FAIL x3_write: ov=%b we=%b wb=%0d want 1/1/9", out_valid, regwe_o, wbdata);
        end
    endtask

    task automatic test_saturation();
        settle();
        drive(1, 6, 1, 32'h55, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_value: got %0d want 15", stall_cnt);
        end
        tick();
        n_tests++;
        if (stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d want 15", stall_cnt);
        end
        clr_cnt = 1; tick(); clr_cnt = 0;
        n_tests++;
        if (stall_cnt !== 4'd0) begin
            n_fail++; $display("FAIL sat_clear: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        settle();
        drive(1, 1, 1, 32'hB1, 0); tick();
        drive(1, 2, 1, 32'hB2, 0); tick();
        #2 rst = 0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd_o !== '0 || wbdata !== '0 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: ov=%b ir=%b rd=%0d wb=%h cnt=%0d want 0/1/0/0/0",
                     out_valid, in_ready, rd_o, wbdata, stall_cnt);
        end
        q.delete(); cnt_m = 0; obs.delete();
        drive(0, 0, 0, 0, 1);
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_random();
        settle();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom % 2), AW'($urandom), 1'($urandom % 2), $urandom, 1'(($urandom % 4) != 0));
            flush   = (($urandom % 16) == 0);
            clr_cnt = (($urandom % 32) == 0);
            tick();
            n_tests++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) || stall_cnt !== CW'(cnt_m)) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: ir=%b ov=%b cnt=%0d want %b/%b/%0d",
                         i, in_ready, out_valid, stall_cnt, q.size() < 2, q.size() > 0, cnt_m);
            end else if (q.size() > 0) begin
                n_tests++;
                if (rd_o !== q[0].rd || wbdata !== q[0].data ||
                    regwe_o !== (q[0].regwe && q[0].rd != 0)) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: rd=%0d wb=%h we=%b want %0d/%h/%b", i, rd_o, wbdata,
                             regwe_o, q[0].rd, q[0].data, q[0].regwe && q[0].rd != 0);
                end
            end
        end
        flush = 0; clr_cnt = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_x0();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Parametrised EX/MEM pipeline boundary register. It is the successor to the plain single-cycle EX/MEM latch.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, synchronous flush, x0-write suppression and a saturating stall counter.
- Sits between the execute stage (upstream) and memory/writeback (downstream).

Parameters:
- DATA_W, 32, width of the result/writeback data.
- ADDR_W, 5, width of the destination register address.
- CNT_W, 16, width of the stall counter.
- ZERO_SUPPRESS, 1, when 1 a write to register address 0 is presented with regwe_o=0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- rd  in  ADDR_W  destination register.
- regwe  in  1  register write enable.
- result  in  DATA_W  execute result.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the output entry.
- rd_o  out  ADDR_W  held destination register.
- regwe_o  out  1  held write enable, qualified.
- wbdata  out  DATA_W  held writeback data.
- clr_cnt  in  1  synchronous clear of the stall counter.
- stall_cnt  out  CNT_W  backpressure cycle count.

Behaviour:
- Storage:
  - Main slot M drives the outputs and carries valid flag m_v.
  - Skid slot S carries valid flag s_v.
- Reset (rst=0, asynchronous):
  - m_v=0, s_v=0.
  - rd_o=0, regwe_o=0, wbdata=0, stall_cnt=0.
  - in_ready=1 while in reset and on the first cycle after release.
- in_ready = !s_v. It is a registered-state function with no combinational path from out_ready.
- Definitions: accept = in_valid & in_ready; drain = m_v & out_ready.
- Per-edge priority, highest first:
  1. flush=1: m_v<=0, s_v<=0. Any same-cycle accept is discarded. Payload registers hold their old values; no output depends on them while invalid.
  2. Otherwise, depending on m_v and drain:
     - M empty or draining: M <= S if s_v, else M <= the input if accept.
     - Moving S into M while accepting: the input is written to S.
     - M full and not draining: an accepted input goes to S.
     - m_v is set if M receives any entry; otherwise m_v clears on drain.
- Ordering is strictly FIFO. S never holds an entry while M is empty.
- Latency and throughput:
  - An entry accepted at edge N is visible at outputs after edge N (1 cycle) when M is free.
  - Sustained throughput is 1 entry per cycle while out_ready=1.
- Output qualification:
  - out_valid = m_v.
  - regwe_o = m_v & M.regwe & !(ZERO_SUPPRESS & M.rd==0).
  - rd_o and wbdata reflect M unconditionally.
- Stall counter:
  - Increments each edge where m_v & !out_ready & !flush.
  - Saturates at all-ones with no wrap.
  - clr_cnt zeroes it. clr_cnt has priority over increment.
- Boundary conditions:
  - Both slots full with out_ready=0: in_ready=0 and upstream holds. Payload on in_* is ignored while in_ready=0.
  - Both full, out_ready=1 and in_valid=1: in_ready=0 this cycle, so the input is not taken. S moves to M and in_ready rises the next cycle.
  - Flush on the same cycle as out_ready=1: the drain still counts as delivered downstream, but nothing new is loaded.
  - Reset asserted mid-transfer: all entries are lost and outputs return to reset values immediately.

Test Plan:
- Reset and first entry: rst=0 for 3 cycles, then release. Present in_valid=1, rd=5, regwe=1, result=0xDEADBEEF, out_ready=1. Required: out_valid=1, rd_o=5, regwe_o=1, wbdata=0xDEADBEEF one cycle later; all outputs 0 during reset.
- Streaming: send results 1..8 back-to-back with out_ready=1. Required: 8 consecutive output cycles in order 1..8, in_ready constantly 1, stall_cnt=0.
- Backpressure and skid:
  - Send A=0x11, B=0x22, C=0x33 back-to-back with out_ready=0 from the cycle A is visible.
  - Required: A held in M, B in S, in_ready=0 so C waits.
  - Then raise out_ready. Required: outputs A, B, C in order and no loss; stall_cnt equals the number of stalled cycles.
- Flush: with both slots full plus in_valid=1 and result=0x44, assert flush one cycle. Required: out_valid=0 and in_ready=1 next cycle; 0x44 never appears on the outputs.
- x0 suppression: rd=0, regwe=1, result=7 (ZERO_SUPPRESS=1). Required: out_valid=1, regwe_o=0, wbdata=7.
- Counter saturation: CNT_W=4, hold out_ready=0 with m_v=1 for 20 cycles. Required: stall_cnt=15 and holds; clr_cnt=1 gives 0 on the next cycle.
